// File: rtl/ieee754_pkg.sv
// ieee754_pkg
//   Shared IEEE-754 single-precision definitions used by the float/integer
//   conversion paths: field widths, exponent bias, converter FSM states and
//   operand classes.
package ieee754_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Denormals are grouped with zero: they are flushed on conversion.
    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        NORM    = 2'd1,
        INF_NAN = 2'd2
    } fp32_class_t;

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack
//   Combinational split of an IEEE-754 single into its fields, operand class
//   and signed unbiased exponent.
// Ports:
//   flt_value  in   32      operand {sign, exp[7:0], frac[22:0]}
//   sign       out  1       sign bit
//   frac       out  23      fraction field (hidden bit not included)
//   cls        out  class   ZERO (exp==0), INF_NAN (exp==255), NORM otherwise
//   e          out  9 (s)   exp - 127
module fp32_unpack
    import ieee754_pkg::*;
(
    input  logic [31:0]        flt_value,
    output logic               sign,
    output logic [FRAC_W-1:0]  frac,
    output fp32_class_t        cls,
    output logic signed [8:0]  e
);

    logic [EXP_W-1:0] exp_f;

    assign sign  = flt_value[31];
    assign exp_f = flt_value[30:23];
    assign frac  = flt_value[22:0];

    // Zero-extend the biased exponent before subtracting so E spans -127..128.
    assign e = signed'({1'b0, exp_f}) - signed'(9'(BIAS));

    always_comb begin
        cls = NORM;
        if (exp_f == EXP_W'(EXP_MAX)) begin
            cls = INF_NAN;
        end else if (exp_f == '0) begin
            cls = ZERO;
        end
    end

endmodule

// File: rtl/fp_to_int_conv.sv
// fp_to_int_conv
//   Converts an IEEE-754 single into an INT_W-bit unsigned magnitude plus a
//   sign indication (pos=1 for sign bit clear), truncating toward zero.
//   Alignment uses an iterative shifter moving at most STEP bits per cycle.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   flt_value  in   32     IEEE-754 single operand
//   in_valid   in   1      operand present
//   in_ready   out  1      block can accept (IDLE only)
//   int_val    out  INT_W  truncated integer magnitude
//   pos        out  1      1 = sign bit clear, 0 = sign bit set
//   flag       out  1      overflow / Inf / NaN indication
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
module fp_to_int_conv
    import ieee754_pkg::*;
#(
    parameter int INT_W = 128,
    parameter int STEP  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       flt_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [INT_W-1:0]  int_val,
    output logic              pos,
    output logic              flag,
    output logic              out_valid,
    input  logic              out_ready
);

    // rem must hold both the largest left shift (INT_W-24) and the largest
    // right shift (23), plus room for STEP up to 32.
    localparam int CL = $clog2(INT_W);
    localparam int RW = ((CL > 5) ? CL : 5) + 1;
    localparam logic [RW-1:0] STEP_V = RW'(STEP);

    conv_state_t        state, state_n;
    logic [INT_W-1:0]   acc, acc_n;
    logic [RW-1:0]      rem, rem_n;
    logic               dir, dir_n;      // 1 = left, 0 = right
    logic               pos_r, pos_n;
    logic               flag_r, flag_n;

    logic               u_sign;
    logic [FRAC_W-1:0]  u_frac;
    fp32_class_t        u_cls;
    logic signed [8:0]  u_e;

    logic [RW-1:0]      amt;
    int                 e_int;

    fp32_unpack u_unpack (
        .flt_value (flt_value),
        .sign      (u_sign),
        .frac      (u_frac),
        .cls       (u_cls),
        .e         (u_e)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign int_val   = acc;
    assign pos       = pos_r;
    assign flag      = flag_r;

    // Shift distance for this cycle: the remaining count, capped at STEP.
    assign amt = (rem < STEP_V) ? rem : STEP_V;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        dir_n   = dir;
        pos_n   = pos_r;
        flag_n  = flag_r;
        e_int   = int'(u_e);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    pos_n   = ~u_sign;
                    flag_n  = 1'b0;
                    rem_n   = '0;
                    dir_n   = 1'b0;
                    acc_n   = '0;
                    state_n = DONE;
                    case (u_cls)
                        INF_NAN: begin
                            acc_n  = '1;
                            flag_n = 1'b1;
                        end
                        NORM: begin
                            if (e_int > INT_W - 1) begin
                                acc_n  = '1;
                                flag_n = 1'b1;
                            end else if (e_int >= 0) begin
                                // Hidden bit sits at bit 23; move it to bit E.
                                acc_n   = INT_W'({1'b1, u_frac});
                                state_n = SHIFT;
                                if (e_int >= FRAC_W) begin
                                    dir_n = 1'b1;
                                    rem_n = RW'(e_int - FRAC_W);
                                end else begin
                                    dir_n = 1'b0;
                                    rem_n = RW'(FRAC_W - e_int);
                                end
                            end
                        end
                        default: ;  // ZERO and denormals flush to 0
                    endcase
                end
            end

            SHIFT: begin
                acc_n = dir ? (acc << amt) : (acc >> amt);
                rem_n = rem - amt;
                if (rem <= STEP_V) begin
                    state_n = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            dir    <= 1'b0;
            pos_r  <= 1'b1;
            flag_r <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            rem    <= rem_n;
            dir    <= dir_n;
            pos_r  <= pos_n;
            flag_r <= flag_n;
        end
    end

endmodule

// File: tb/tb_fp_to_int_conv.sv
module tb_fp_to_int_conv;

    localparam int INT_W = 128;
    localparam int STEP  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       flt_value;
    logic              in_valid;
    logic              in_ready;
    logic [INT_W-1:0]  int_val;
    logic              pos;
    logic              flag;
    logic              out_valid;
    logic              out_ready;

    int n_chk = 0;
    int n_err = 0;

    fp_to_int_conv #(.INT_W(INT_W), .STEP(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flt_value (flt_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_val   (int_val),
        .pos       (pos),
        .flag      (flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [INT_W-1:0] got, input logic [INT_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: value = 1.frac * 2^E, truncated toward zero, saturating.
    function automatic void model(input logic [31:0] v, output logic [INT_W-1:0] iv,
                                  output logic p, output logic f, output int lat);
        int               ex;
        int               e;
        int               r;
        logic [INT_W-1:0] m;
        ex  = int'(v[30:23]);
        e   = ex - 127;
        m   = INT_W'({1'b1, v[22:0]});
        p   = ~v[31];
        f   = 1'b0;
        iv  = '0;
        lat = 1;
        if (ex == 255) begin
            iv = '1;
            f  = 1'b1;
        end else if (ex == 0 || e < 0) begin
            iv = '0;
        end else if (e > INT_W - 1) begin
            iv = '1;
            f  = 1'b1;
        end else begin
            if (e >= 23) begin
                iv = m * (INT_W'(1) << (e - 23));
                r  = e - 23;
            end else begin
                iv = m / (INT_W'(1) << (23 - e));
                r  = 23 - e;
            end
            lat = 1 + ((r == 0) ? 1 : (r + STEP - 1) / STEP);
        end
    endfunction

    task automatic run(input logic [31:0] v, input int hold);
        logic [INT_W-1:0] e_iv;
        logic             e_p;
        logic             e_f;
        int               e_lat;
        int               lat;
        bit               got;
        model(v, e_iv, e_p, e_f, e_lat);
        @(negedge clk);
        chk("in_ready_idle", INT_W'(in_ready), INT_W'(1));
        flt_value = v;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flt_value = $urandom();
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk("out_valid_timeout", INT_W'(got), INT_W'(1));
        chk("latency", INT_W'(lat), INT_W'(e_lat));
        chk("int_val", int_val, e_iv);
        chk("pos", INT_W'(pos), INT_W'(e_p));
        chk("flag", INT_W'(flag), INT_W'(e_f));
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            flt_value = $urandom();
            @(negedge clk);
            chk("hold_valid", INT_W'(out_valid), INT_W'(1));
            chk("hold_in_ready", INT_W'(in_ready), INT_W'(0));
            chk("hold_int_val", int_val, e_iv);
            chk("hold_pos", INT_W'(pos), INT_W'(e_p));
            chk("hold_flag", INT_W'(flag), INT_W'(e_f));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", INT_W'(out_valid), INT_W'(0));
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] directed [9];
        directed = '{32'h3F800000, 32'hC0B80000, 32'h71800000, 32'h7F000000,
                     32'h7F800000, 32'h7FC00000, 32'h3F000000, 32'h80000000,
                     32'h00000001};

        reset     = 1'b0;
        flt_value = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", INT_W'(in_ready), INT_W'(1));
        chk("rst_out_valid", INT_W'(out_valid), INT_W'(0));
        chk("rst_int_val", int_val, '0);
        chk("rst_pos", INT_W'(pos), INT_W'(1));
        chk("rst_flag", INT_W'(flag), INT_W'(0));
        reset = 1'b1;

        foreach (directed[i]) run(directed[i], 0);

        // Backpressure, then the next operand must still be taken normally.
        run(32'hC0B80000, 5);
        run(32'h3F800000, 0);

        // Reset in the middle of a long left shift.
        @(negedge clk);
        flt_value = 32'h71800000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midshift_busy", INT_W'(in_ready), INT_W'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("abort_out_valid", INT_W'(out_valid), INT_W'(0));
        chk("abort_int_val", int_val, '0);
        chk("abort_in_ready", INT_W'(in_ready), INT_W'(1));
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_result", INT_W'(out_valid), INT_W'(0));
        end
        run(32'h3F800000, 0);

        for (int k = 0; k < 250; k++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            v = $urandom();
            if (sel == 0)      v[30:23] = 8'hFF;
            else if (sel == 1) v[30:23] = 8'h00;
            else               v[30:23] = 8'($urandom_range(100, 254));
            run(v, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_to_int_conv.md
Name: fp_to_int_conv

Overview:
Converts an IEEE-754 single-precision value into a 128-bit unsigned magnitude plus a sign indication. It is the inverse of the integer-to-float path. Sign polarity matches that path: pos=1 means a non-negative result. Alignment is done by an iterative shifter, a bounded number of bits per cycle, with valid/ready handshakes on both sides so it can sit between the float datapath and integer consumers.

Parameters:
INT_W, 128, output magnitude width; values ≥ 2^INT_W saturate.
STEP, 8, maximum shift distance applied per SHIFT cycle (1..32).

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
flt_value  input  32  IEEE-754 single operand {sign, exp[7:0], frac[22:0]}
in_valid  input  1  operand present
in_ready  output  1  block can accept; high only in IDLE
int_val  output  INT_W  truncated integer magnitude
pos  output  1  1 = sign bit clear, 0 = sign bit set
flag  output  1  overflow / Inf / NaN indication
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, in_ready=1, out_valid=0, int_val=0, pos=1, flag=0, internal shift count=0. This applies in any state and aborts an in-flight conversion without producing a result.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register the sign and classify the operand using E = exp − 127:
  - exp==255 (Inf/NaN): int_val = all ones, flag=1, go to DONE.
  - exp==0 (zero or denormal, flushed): int_val=0, flag=0, go to DONE.
  - E<0 (|x|<1): int_val=0, flag=0, go to DONE (truncation toward zero).
  - E>INT_W−1: int_val = all ones, flag=1, go to DONE.
  - Otherwise: load acc = {1, frac} zero-extended to INT_W. Set dir=left, rem=E−23 when E≥23; set dir=right, rem=23−E when E<23. Go to SHIFT.
- SHIFT: each cycle shifts acc by min(rem, STEP) in direction dir (zero fill, right-shift truncates) and decrements rem by the same amount.
  - Transition to DONE in the cycle where the pre-shift rem ≤ STEP, including rem==0.
  - Number of SHIFT cycles = max(1, ceil(rem/STEP)).
- DONE: out_valid=1. int_val, pos and flag are stable and must not change while out_valid=1 && out_ready=0. On out_ready, return to IDLE; out_valid drops next cycle.
- pos = ~sign for every class, including zero (−0.0 gives pos=0, int_val=0).
- Latency from the accept edge to out_valid high:
  - 1 edge for special, zero and underflow cases.
  - 1 + max(1, ceil(rem/STEP)) edges otherwise.
- No new accept while busy. in_ready=0 in SHIFT and DONE; there is no overlap between the DONE handshake and a new accept.
- in_valid while not ready is ignored, and flt_value is not sampled.
- Width rule: the largest legal E is INT_W−1, so the maximum left shift is INT_W−24. The hidden bit lands exactly at bit E, so no bits are lost on a left shift.

Decomposition:
- Shared package ieee754_pkg:
  - Constants: EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=255.
  - A conv_state_t enum {IDLE, SHIFT, DONE}.
  - A fp32 class enum {ZERO, NORM, INF_NAN}.
- One sub-module fp32_unpack (combinational): splits sign/exp/frac and produces the class plus signed unbiased exponent E. It is shared with the integer-to-float path for checking.

Test Plan:
- 0x3F800000 (1.0) → 3 SHIFT cycles (rem=23), int_val=1, pos=1, flag=0, out_valid 4 edges after accept.
- 0xC0B80000 (−5.75) → int_val=5, pos=0, flag=0 (fraction truncated).
- 0x71800000 (2^100) → left rem=77 gives 10 SHIFT cycles, int_val=1<<100, flag=0. 0x7F000000 (2^127) → int_val bit127 only, flag=0.
- 0x7F800000 (+Inf), 0x7FC00000 (NaN) → int_val=all ones, flag=1, 1-edge latency. 0x3F000000 (0.5) → int_val=0, flag=0. 0x80000000 → int_val=0, pos=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, second in_valid ignored. Raise out_ready → IDLE, then the next operand is accepted.
- Drive reset=0 mid-SHIFT for 1 cycle → IDLE, out_valid=0, int_val=0. The next conversion of 1.0 completes correctly.
